// File: rtl/c7b_lsu_pkg.sv
// c7b LSU shared types: FSM state encoding, access size codes, strobe constants and alignment helpers.
// Latency: n/a (types and pure functions only).
// Backpressure: n/a.
// Optional feature macro used by the importing RTL: C7B_LSU_BUSERR_EN.
package c7b_lsu_pkg;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_LS1  = 3'd1,
    ST_REQ  = 3'd2,
    ST_RESP = 3'd3,
    ST_LS3  = 3'd4
  } lsu_state_t;

  localparam logic [1:0] SZ_B   = 2'd0;
  localparam logic [1:0] SZ_H   = 2'd1;
  localparam logic [1:0] SZ_W   = 2'd2;
  localparam logic [1:0] SZ_RSV = 2'd3;

  localparam logic [3:0] STRB_NONE = 4'b0000;
  localparam logic [3:0] STRB_B0   = 4'b0001;
  localparam logic [3:0] STRB_LO_H = 4'b0011;
  localparam logic [3:0] STRB_HI_H = 4'b1100;
  localparam logic [3:0] STRB_W    = 4'b1111;

  localparam int LANE_W = 8;

  // The reserved size code behaves exactly like a word access.
  function automatic logic [1:0] norm_size(input logic [1:0] sz);
    return (sz == SZ_RSV) ? SZ_W : sz;
  endfunction

  // Expects a normalized size.
  function automatic logic is_misaligned(input logic [1:0] sz, input logic [1:0] addr_lo);
    return ((sz == SZ_H) && addr_lo[0]) || ((sz == SZ_W) && (addr_lo != 2'b00));
  endfunction

endpackage

// File: rtl/c7blsu_align.sv
// Store lane steering / strobe generation and load lane extract with sign/zero extension.
// Latency: purely combinational.
// Backpressure: none; no state.
// Ports: size/addr_lo/uns describe the access; st_data -> st_lanes/st_strb; ld_word -> ld_data.
module c7blsu_align
  import c7b_lsu_pkg::*;
#(
  parameter int DW = 32
) (
  input  logic [1:0]    size,
  input  logic [1:0]    addr_lo,
  input  logic          uns,
  input  logic [DW-1:0] st_data,
  output logic [DW-1:0] st_lanes,
  output logic [3:0]    st_strb,
  input  logic [DW-1:0] ld_word,
  output logic [DW-1:0] ld_data
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    st_lanes = st_data;
    st_strb  = STRB_W;
    case (size)
      SZ_B: begin
        st_lanes = {4{st_data[7:0]}};
        st_strb  = STRB_B0 << addr_lo;
      end
      SZ_H: begin
        st_lanes = {2{st_data[15:0]}};
        st_strb  = addr_lo[1] ? STRB_HI_H : STRB_LO_H;
      end
      default: ;
    endcase
  end

  always_comb begin
    ld_byte = ld_word[{addr_lo, 3'b000} +: LANE_W];
    ld_half = addr_lo[1] ? ld_word[31:16] : ld_word[15:0];
    ld_data = ld_word;
    case (size)
      SZ_B:    ld_data = {{24{~uns & ld_byte[7]}}, ld_byte};
      SZ_H:    ld_data = {{16{~uns & ld_half[15]}}, ld_half};
      default: ;
    endcase
  end

endmodule

// File: rtl/c7blsu_ctl.sv
// c7b LSU sequencer: one memory op, ls1 alignment check, single-outstanding bus exchange, one completion pulse.
// Latency: ale at N+1; request from N+2; completion pulse (ls3) at N+4 minimum, stretched by bus stalls.
// Backpressure: request held with fields stable until bus_req_ready; waits indefinitely for bus_resp_valid.
// Ports: lsu_*_e op inputs; lsu_* completion/status outputs; bus_req_* / bus_resp_* data bus.
// Macro C7B_LSU_BUSERR_EN: when defined, a response error yields lsu_except_buserr_ls3 instead of normal completion.
module c7blsu_ctl
  import c7b_lsu_pkg::*;
#(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          lsu_vld_e,
  input  logic          lsu_st_e,
  input  logic [1:0]    lsu_size_e,
  input  logic          lsu_unsigned_e,
  input  logic [AW-1:0] lsu_addr_e,
  input  logic [DW-1:0] lsu_wdata_e,
  input  logic [4:0]    lsu_rd_e,
  output logic          lsu_busy,
  output logic          lsu_except_ale_ls1,
  output logic [AW-1:0] lsu_badv_ls1,
  output logic          lsu_data_valid_ls3,
  output logic [DW-1:0] lsu_rdata_ls3,
  output logic [4:0]    lsu_rd_ls3,
  output logic          lsu_wr_fin_ls3,
  output logic          lsu_except_buserr_ls3,
  output logic          bus_req_valid,
  input  logic          bus_req_ready,
  output logic          bus_req_we,
  output logic [AW-1:0] bus_req_addr,
  output logic [3:0]    bus_req_wstrb,
  output logic [DW-1:0] bus_req_wdata,
  input  logic          bus_resp_valid,
  input  logic [DW-1:0] bus_resp_rdata,
  input  logic          bus_resp_err
);

  lsu_state_t    state;
  logic          op_st;
  logic [1:0]    op_size;
  logic          op_uns;
  logic [AW-1:0] op_addr;
  logic [DW-1:0] op_wdata;
  logic [4:0]    op_rd;

  logic          e_mis;
  logic [DW-1:0] st_lanes;
  logic [3:0]    st_strb;
  logic [DW-1:0] ld_data;

  // ale is a registered pulse visible during LS1, so the check runs on the e-stage inputs.
  assign e_mis    = is_misaligned(norm_size(lsu_size_e), lsu_addr_e[1:0]);
  assign lsu_busy = (state != ST_IDLE);

  c7blsu_align #(.DW(DW)) u_align (
    .size     (op_size),
    .addr_lo  (op_addr[1:0]),
    .uns      (op_uns),
    .st_data  (op_wdata),
    .st_lanes (st_lanes),
    .st_strb  (st_strb),
    .ld_word  (bus_resp_rdata),
    .ld_data  (ld_data)
  );

`ifndef C7B_LSU_BUSERR_EN
  logic unused_resp_err;
  assign unused_resp_err       = bus_resp_err;
  assign lsu_except_buserr_ls3 = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state              <= ST_IDLE;
      op_st              <= 1'b0;
      op_size            <= SZ_B;
      op_uns             <= 1'b0;
      op_addr            <= '0;
      op_wdata           <= '0;
      op_rd              <= '0;
      lsu_except_ale_ls1 <= 1'b0;
      lsu_badv_ls1       <= '0;
      lsu_data_valid_ls3 <= 1'b0;
      lsu_rdata_ls3      <= '0;
      lsu_rd_ls3         <= '0;
      lsu_wr_fin_ls3     <= 1'b0;
`ifdef C7B_LSU_BUSERR_EN
      lsu_except_buserr_ls3 <= 1'b0;
`endif
      bus_req_valid      <= 1'b0;
      bus_req_we         <= 1'b0;
      bus_req_addr       <= '0;
      bus_req_wstrb      <= STRB_NONE;
      bus_req_wdata      <= '0;
    end else begin
      // Completion/exception outputs are single-cycle pulses by default.
      lsu_except_ale_ls1 <= 1'b0;
      lsu_badv_ls1       <= '0;
      lsu_data_valid_ls3 <= 1'b0;
      lsu_wr_fin_ls3     <= 1'b0;
`ifdef C7B_LSU_BUSERR_EN
      lsu_except_buserr_ls3 <= 1'b0;
`endif
      case (state)
        ST_IDLE: begin
          if (lsu_vld_e) begin
            op_st              <= lsu_st_e;
            op_size            <= norm_size(lsu_size_e);
            op_uns             <= lsu_unsigned_e;
            op_addr            <= lsu_addr_e;
            op_wdata           <= lsu_wdata_e;
            op_rd              <= lsu_rd_e;
            lsu_except_ale_ls1 <= e_mis;
            lsu_badv_ls1       <= e_mis ? lsu_addr_e : '0;
            state              <= ST_LS1;
          end
        end
        ST_LS1: begin
          if (is_misaligned(op_size, op_addr[1:0])) begin
            state <= ST_IDLE;
          end else begin
            bus_req_valid <= 1'b1;
            bus_req_we    <= op_st;
            bus_req_addr  <= {op_addr[AW-1:2], 2'b00};
            bus_req_wstrb <= op_st ? st_strb : STRB_NONE;
            bus_req_wdata <= op_st ? st_lanes : '0;
            state         <= ST_REQ;
          end
        end
        ST_REQ: begin
          if (bus_req_ready) begin
            bus_req_valid <= 1'b0;
            state         <= ST_RESP;
          end
        end
        ST_RESP: begin
          // The response is captured here and shows up as the LS3-cycle pulse.
          if (bus_resp_valid) begin
            state <= ST_LS3;
`ifdef C7B_LSU_BUSERR_EN
            if (bus_resp_err) begin
              lsu_except_buserr_ls3 <= 1'b1;
            end else
`endif
            if (op_st) begin
              lsu_wr_fin_ls3 <= 1'b1;
            end else begin
              lsu_data_valid_ls3 <= 1'b1;
              lsu_rdata_ls3      <= ld_data;
              lsu_rd_ls3         <= op_rd;
            end
          end
        end
        ST_LS3:  state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
